// File: rtl/pg_seq_ctrl.sv
// Playback sequencer for the 4-bit pattern generator: small pattern memory plus a
// two-state player that steps through entries 0..len, holding each code div+1 cycles.
module pg_seq_ctrl #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 4,
  parameter int DIV_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic [AW-1:0]     cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              stop,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              busy,
  output logic              step,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_n;
  logic [AW-1:0]       idx_q, idx_n, len_q, len_n;
  logic [DIV_W-1:0]    cnt_q, cnt_n, div_q, div_n;
  logic                loop_q, loop_n;
  logic [CODE_W-1:0]   code_q, code_n;
  logic                valid_q, valid_n, busy_q, busy_n;
  logic                step_q, step_n, done_q, done_n;
  logic [AW-1:0]       idx_inc;

  logic [CODE_W-1:0]   mem [DEPTH];

  // NOTE: the pattern memory has no reset so it maps onto plain storage; its
  // contents survive rst_n and are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en && ena && state_q == IDLE) mem[wr_addr] <= wr_data;
  end

  assign idx_inc = idx_q + AW'(1);

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    len_n   = len_q;
    div_n   = div_q;
    loop_n  = loop_q;
    code_n  = code_q;
    valid_n = valid_q;
    busy_n  = busy_q;
    step_n  = 1'b0;
    done_n  = 1'b0;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop) begin
            len_n   = cfg_len;
            div_n   = cfg_div;
            loop_n  = cfg_loop;
            idx_n   = '0;
            cnt_n   = cfg_div;
            code_n  = mem[0];
            valid_n = 1'b1;
            busy_n  = 1'b1;
            step_n  = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          // Abort wins over any step or completion in the same cycle.
          if (stop || (cnt_q == '0 && idx_q == len_q && !loop_q)) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
            code_n  = '0;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = !stop;
          end else if (cnt_q != '0) begin
            cnt_n = cnt_q - DIV_W'(1);
          end else if (idx_q != len_q) begin
            idx_n  = idx_inc;
            cnt_n  = div_q;
            code_n = mem[idx_inc];
            step_n = 1'b1;
          end else begin
            idx_n  = '0;
            cnt_n  = div_q;
            code_n = mem[0];
            step_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      loop_q  <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      div_q   <= div_n;
      loop_q  <= loop_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      step_q  <= step_n;
      done_q  <= done_n;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  // Pulses are masked immediately when ena drops, not one edge later.
  assign step       = step_q & ena;
  assign done       = done_q & ena;

endmodule

// File: tb/tb_pg_seq_ctrl.sv
// Scoreboard bench for pg_seq_ctrl: directed runs push expected step/done events;
// a negedge monitor pops and compares them whenever the DUT pulses step or done.
module tb_pg_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [2:0] cfg_len = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] code_out;
  logic       code_valid, busy, step, done;

  pg_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_loop(cfg_loop),
    .start(start), .stop(stop),
    .code_out(code_out), .code_valid(code_valid), .busy(busy),
    .step(step), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       off;
    logic [3:0] code;
    logic     busy;
    logic     done;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   t0 = 0;
  int   errors = 0;
  int   n_checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: every step/done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (step === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_offset", cyc - t0, e.off);
        check("code_out", int'(code_out), int'(e.code));
        check("busy", int'(busy), int'(e.busy));
        check("code_valid", int'(code_valid), int'(e.busy));
        check("done", int'(done), int'(e.done));
        check("step", int'(step), int'(!e.done));
      end
    end
  end

  task automatic push(input int off, input logic [3:0] code, input logic b, input logic d);
    exp_t e;
    e.off = off; e.code = code; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] len, input logic [7:0] div, input logic lp);
    cfg_len = len; cfg_div = div; cfg_loop = lp;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_off(input int n);
    for (int k = 0; k < 500 && (cyc - t0) < n; k++) tick();
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500 && (exp_q.size() != 0 || busy); k++) tick();
    check("drain_timeout", exp_q.size(), 0);
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_code", int'(code_out), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    write_mem(3'd0, 4'h3);
    write_mem(3'd1, 4'hA);
    write_mem(3'd2, 4'h5);
    write_mem(3'd3, 4'hF);

    // One-shot, div=1; mid-run write to entry 1 and cfg_div change must be ignored.
    push(1, 4'h3, 1, 0); push(3, 4'hA, 1, 0); push(5, 4'h5, 1, 0); push(7, 4'hF, 1, 0);
    push(9, 4'h0, 0, 1);
    do_start(3'd3, 8'd1, 1'b0);
    wait_off(2);
    cfg_div = 8'd5;
    write_mem(3'd1, 4'h0);
    drain();

    // Next run picks up div=5 (hold 6) and still reads A from entry 1.
    push(1, 4'h3, 1, 0); push(7, 4'hA, 1, 0); push(13, 4'h5, 1, 0); push(19, 4'hF, 1, 0);
    push(25, 4'h0, 0, 1);
    do_start(3'd3, 8'd5, 1'b0);
    drain();

    // Loop, div=0, stop sampled after cycle 6.
    push(1, 4'h3, 1, 0); push(2, 4'hA, 1, 0); push(3, 4'h5, 1, 0);
    push(4, 4'hF, 1, 0); push(5, 4'h3, 1, 0); push(6, 4'hA, 1, 0);
    do_start(3'd3, 8'd0, 1'b1);
    wait_off(6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_code", int'(code_out), 0);
    check("stop_valid", int'(code_valid), 0);
    check("stop_done", int'(done), 0);
    drain();

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", int'(busy), 0);
    tick();
    check("ss_busy_later", int'(busy), 0);
    check("ss_valid", int'(code_valid), 0);

    // ena low for 4 edges after cycle 2: everything shifts by 4.
    push(1, 4'h3, 1, 0); push(7, 4'hA, 1, 0); push(9, 4'h5, 1, 0); push(11, 4'hF, 1, 0);
    push(13, 4'h0, 0, 1);
    do_start(3'd3, 8'd1, 1'b0);
    wait_off(2);
    ena = 1'b0;
    tick(); tick();
    check("frz_code", int'(code_out), 3);
    check("frz_busy", int'(busy), 1);
    tick(); tick();
    ena = 1'b1;
    drain();

    // len=0, div=0, one-shot: single step then done.
    push(1, 4'h3, 1, 0); push(2, 4'h0, 0, 1);
    do_start(3'd0, 8'd0, 1'b0);
    drain();

    // Async reset mid-run at idx=2, cnt=3.
    push(1, 4'h3, 1, 0); push(7, 4'hA, 1, 0); push(13, 4'h5, 1, 0);
    do_start(3'd3, 8'd5, 1'b0);
    wait_off(15);
    check("pre_rst_code", int'(code_out), 5);
    rst_n = 1'b0;
    #1;
    check("arst_code", int'(code_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(code_valid), 0);
    check("arst_queue", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Replay confirms memory survived reset.
    push(1, 4'h3, 1, 0); push(2, 4'hA, 1, 0); push(3, 4'h5, 1, 0); push(4, 4'hF, 1, 0);
    push(5, 4'h0, 0, 1);
    do_start(3'd3, 8'd0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
